// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Arbitrates icache/dcache accesses onto one RAM port, dcache first
//            with a starvation cap, error/timeout abort and a sticky error flag.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int STARVE_LIM = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        iwait,
    output logic        dwait,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        memerr
);

    localparam int CW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
    localparam logic [CW-1:0] c_starve_lim = CW'(STARVE_LIM);
    localparam logic [8:0]    c_timeout    = 9'(TIMEOUT);
    localparam logic [1:0]    c_rs_access  = 2'd2;
    localparam logic [1:0]    c_rs_error   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERV_D = 2'd1,
        SERV_I = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] dcnt_q, dcnt_d;
    logic [8:0]    tcnt_q, tcnt_d;
    logic          memerr_q, memerr_d;

    logic          w_dreq;
    logic          w_starving;
    logic          w_req_granted;
    logic [8:0]    w_tnext;

    assign w_dreq     = dREN | dWEN;
    assign w_starving = (dcnt_q == c_starve_lim) && iREN;
    assign w_tnext    = tcnt_q + 9'd1;

    assign iload  = ramload;
    assign dload  = ramload;
    assign memerr = memerr_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            dcnt_q   <= '0;
            tcnt_q   <= '0;
            memerr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            tcnt_q   <= tcnt_d;
            memerr_q <= memerr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        dcnt_d        = dcnt_q;
        tcnt_d        = tcnt_q;
        memerr_d      = memerr_q;
        ramREN        = 1'b0;
        ramWEN        = 1'b0;
        ramaddr       = '0;
        ramstore      = '0;
        iwait         = 1'b1;
        dwait         = 1'b1;
        w_req_granted = 1'b0;

        case (state_q)
            IDLE: begin
                tcnt_d = '0;
                if (w_dreq && !w_starving) begin
                    state_d = SERV_D;
                    if (!iREN)
                        dcnt_d = '0;
                    else if (dcnt_q != c_starve_lim)
                        dcnt_d = dcnt_q + CW'(1);
                end else if (iREN) begin
                    state_d = SERV_I;
                    dcnt_d  = '0;
                end
            end
            SERV_D: begin
                ramaddr       = daddr;
                ramstore      = dstore;
                ramWEN        = dWEN;
                ramREN        = dREN & ~dWEN;
                w_req_granted = w_dreq;
            end
            SERV_I: begin
                ramaddr       = iaddr;
                ramREN        = 1'b1;
                w_req_granted = iREN;
            end
            default: state_d = IDLE;
        endcase

        // A dropped request abandons the access silently; otherwise the RAM
        // status decides between completion, error abort and timeout.
        if (state_q == SERV_D || state_q == SERV_I) begin
            if (!w_req_granted) begin
                state_d = IDLE;
            end else if (ramstate == c_rs_access) begin
                state_d = IDLE;
                if (state_q == SERV_D)
                    dwait = 1'b0;
                else
                    iwait = 1'b0;
            end else if (ramstate == c_rs_error) begin
                memerr_d = 1'b1;
                state_d  = IDLE;
            end else begin
                tcnt_d = w_tnext;
                if (w_tnext == c_timeout) begin
                    memerr_d = 1'b1;
                    state_d  = IDLE;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Randomized and directed self-checking bench for mem_arbiter.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int STARVE_LIM = 4;
    localparam int TIMEOUT    = 255;

    logic        CLK  = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
    logic [1:0]  ramstate = 2'd0;
    logic        iwait, dwait, ramREN, ramWEN, memerr;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.STARVE_LIM(STARVE_LIM), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Transaction-level model: who holds the RAM, how long it has waited,
    // how many dcache grants in a row were given while icache was waiting.
    int m_grant  = 0;   // 0 none, 1 dcache, 2 icache
    int m_served = 0;
    int m_streak = 0;
    bit m_err    = 1'b0;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_grant = 0; m_served = 0; m_streak = 0; m_err = 1'b0;
        end else if (m_grant == 0) begin
            m_served = 0;
            if ((dREN || dWEN) && !(m_streak == STARVE_LIM && iREN)) begin
                m_grant  = 1;
                m_streak = iREN ? ((m_streak < STARVE_LIM) ? m_streak + 1 : STARVE_LIM) : 0;
            end else if (iREN) begin
                m_grant  = 2;
                m_streak = 0;
            end
        end else begin
            if (!(m_grant == 1 ? (dREN || dWEN) : iREN)) m_grant = 0;
            else if (ramstate == 2'd2) m_grant = 0;
            else if (ramstate == 2'd3) begin m_err = 1'b1; m_grant = 0; end
            else begin
                m_served = m_served + 1;
                if (m_served == TIMEOUT) begin m_err = 1'b1; m_grant = 0; end
            end
        end
    end

    logic [31:0] e_addr, e_store;
    logic        e_ren, e_wen, e_iw, e_dw;

    always @(negedge CLK) begin
        if (chk_en) begin
            e_addr = '0; e_store = '0; e_ren = 1'b0; e_wen = 1'b0; e_iw = 1'b1; e_dw = 1'b1;
            if (m_grant == 1) begin
                e_addr = daddr; e_store = dstore; e_wen = dWEN; e_ren = dREN && !dWEN;
                if ((dREN || dWEN) && ramstate == 2'd2) e_dw = 1'b0;
            end else if (m_grant == 2) begin
                e_addr = iaddr; e_ren = 1'b1;
                if (iREN && ramstate == 2'd2) e_iw = 1'b0;
            end
            chk("m_ramaddr", ramaddr, e_addr);
            chk("m_ramstore", ramstore, e_store);
            chk("m_ramREN", 32'(ramREN), 32'(e_ren));
            chk("m_ramWEN", 32'(ramWEN), 32'(e_wen));
            chk("m_iwait", 32'(iwait), 32'(e_iw));
            chk("m_dwait", 32'(dwait), 32'(e_dw));
            chk("m_memerr", 32'(memerr), 32'(m_err));
            chk("m_iload", iload, ramload);
            chk("m_dload", dload, ramload);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        tick();
        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = 2'd0;
        tick();
        nRST = 1'b1;
    endtask

    int cnt, seq, npulse, r;

    initial begin
        chk_en = 1'b1;
        tick();
        #3;
        chk("rst_ramREN", 32'(ramREN), 32'd0);
        chk("rst_ramWEN", 32'(ramWEN), 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_iwait", 32'(iwait), 32'd1);
        chk("rst_dwait", 32'(dwait), 32'd1);
        chk("rst_memerr", 32'(memerr), 32'd0);

        // icache read with two BUSY cycles
        do_reset();
        iREN = 1'b1; iaddr = 32'h40; ramstate = 2'd1; #3;
        chk("ird_c0_ramREN", 32'(ramREN), 32'd0);
        tick(); #3;
        chk("ird_c1_ramREN", 32'(ramREN), 32'd1);
        chk("ird_c1_iwait", 32'(iwait), 32'd1);
        tick(); #3;
        chk("ird_c2_iwait", 32'(iwait), 32'd1);
        tick(); ramstate = 2'd2; ramload = 32'h1234_5678; #3;
        chk("ird_c3_iwait", 32'(iwait), 32'd0);
        chk("ird_c3_iload", iload, 32'h1234_5678);
        chk("ird_c3_ramaddr", ramaddr, 32'h40);
        tick(); iREN = 1'b0; ramstate = 2'd0;

        // simultaneous icache read and dcache write
        do_reset();
        iREN = 1'b1; iaddr = 32'h40; dWEN = 1'b1; daddr = 32'h80; dstore = 32'hDEAD_BEEF;
        ramstate = 2'd1;
        tick(); ramstate = 2'd2; #3;
        chk("wr_ramWEN", 32'(ramWEN), 32'd1);
        chk("wr_ramREN", 32'(ramREN), 32'd0);
        chk("wr_ramstore", ramstore, 32'hDEAD_BEEF);
        chk("wr_ramaddr", ramaddr, 32'h80);
        chk("wr_dwait", 32'(dwait), 32'd0);
        chk("wr_iwait", 32'(iwait), 32'd1);
        tick(); dWEN = 1'b0; ramstate = 2'd1;
        tick(); #3;
        chk("wr_then_i_addr", ramaddr, 32'h40);
        chk("wr_then_i_ren", 32'(ramREN), 32'd1);
        chk("wr_then_i_store", ramstore, 32'd0);
        tick(); iREN = 1'b0; ramstate = 2'd0;

        // starvation cap: D D D D I D
        do_reset();
        iREN = 1'b1; dREN = 1'b1; ramstate = 2'd2; iaddr = 32'h40; daddr = 32'h80;
        seq = 0; npulse = 0;
        for (int i = 0; i < 12; i++) begin
            #3;
            if (!dwait) begin seq = seq * 2; npulse++; end
            if (!iwait) begin seq = seq * 2 + 1; npulse++; end
            tick();
        end
        chk("starve_npulse", 32'(npulse), 32'd6);
        chk("starve_order", 32'(seq), 32'd2);
        iREN = 1'b0; dREN = 1'b0; ramstate = 2'd0;

        // randomized traffic with periodic resets
        for (int blk = 0; blk < 4; blk++) begin
            do_reset();
            for (int c = 0; c < 600; c++) begin
                tick();
                iREN = ($urandom_range(0, 3) != 0);
                dREN = ($urandom_range(0, 2) == 0);
                dWEN = ($urandom_range(0, 3) == 0);
                iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
                r = $urandom_range(0, 99);
                ramstate = (r < 30) ? 2'd0 : (r < 60) ? 2'd1 : (r < 97) ? 2'd2 : 2'd3;
                if (m_grant == 1 && !(dREN || dWEN)) ramstate = 2'd1;
                if (m_grant == 2 && !iREN) ramstate = 2'd1;
            end
        end

        // error during dcache service
        do_reset();
        dREN = 1'b1; dWEN = 1'b0; iREN = 1'b0; daddr = 32'h200; ramstate = 2'd1;
        tick(); ramstate = 2'd3; #3;
        chk("err_dwait", 32'(dwait), 32'd1);
        chk("err_memerr_pre", 32'(memerr), 32'd0);
        tick(); dREN = 1'b0; ramstate = 2'd0; #3;
        chk("err_memerr", 32'(memerr), 32'd1);
        chk("err_idle_ren", 32'(ramREN), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        #3;
        chk("err_sticky", 32'(memerr), 32'd1);
        do_reset(); #3;
        chk("err_cleared", 32'(memerr), 32'd0);

        // timeout on a stuck BUSY RAM
        dREN = 1'b1; daddr = 32'h300; ramstate = 2'd1; cnt = 0;
        for (int i = 0; i < 400; i++) begin
            tick(); #3;
            if (ramREN) cnt++;
            else break;
        end
        chk("tmo_cycles", 32'(cnt), 32'(TIMEOUT));
        chk("tmo_memerr", 32'(memerr), 32'd1);
        tick(); dREN = 1'b0; ramstate = 2'd0;

        // reset in the middle of an icache service
        do_reset();
        iREN = 1'b1; iaddr = 32'h44; ramstate = 2'd1;
        tick(); #3;
        chk("mrst_c1_ren", 32'(ramREN), 32'd1);
        @(posedge CLK); #2;
        ramstate = 2'd2; nRST = 1'b0; #1;
        chk("mrst_ren", 32'(ramREN), 32'd0);
        chk("mrst_addr", ramaddr, 32'd0);
        chk("mrst_iwait", 32'(iwait), 32'd1);
        chk("mrst_dwait", 32'(dwait), 32'd1);
        tick(); nRST = 1'b1; ramstate = 2'd1; #3;
        chk("mrst_idle", 32'(ramREN), 32'd0);
        tick(); #3;
        chk("mrst_regrant", 32'(ramREN), 32'd1);
        tick(); iREN = 1'b0; ramstate = 2'd0;
        tick(); tick();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIM, default 4: maximum consecutive dcache grants while an icache request is pending.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum cycles a grant waits for ramstate ACCESS before it is aborted.
REQ-003 SHALL have port CLK, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port nRST, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port iREN, input, 1: icache read request.
REQ-006 SHALL have port iaddr, input, 32: icache word address.
REQ-007 SHALL have port dREN, input, 1: dcache read request.
REQ-008 SHALL have port dWEN, input, 1: dcache write request.
REQ-009 SHALL have port daddr, input, 32: dcache word address.
REQ-010 SHALL have port dstore, input, 32: dcache write data.
REQ-011 SHALL have port iwait, output, 1: 0 only in the cycle the icache access completes.
REQ-012 SHALL have port dwait, output, 1: 0 only in the cycle the dcache access completes.
REQ-013 SHALL have port iload, output, 32: read data to icache; equals ramload.
REQ-014 SHALL have port dload, output, 32: read data to dcache; equals ramload.
REQ-015 SHALL have port ramREN, output, 1: RAM read strobe.
REQ-016 SHALL have port ramWEN, output, 1: RAM write strobe.
REQ-017 SHALL have port ramaddr, output, 32: RAM address.
REQ-018 SHALL have port ramstore, output, 32: RAM write data.
REQ-019 SHALL have port ramload, input, 32: RAM read data.
REQ-020 SHALL have port ramstate, input, 2: RAM status; 0=FREE, 1=BUSY, 2=ACCESS, 3=ERROR.
REQ-021 SHALL have port memerr, output, 1: sticky error flag.

Function
REQ-022 SHALL implement the FSM states IDLE, SERV_D and SERV_I, held in a registered state.
REQ-023 In IDLE, if (dREN|dWEN) and not starving, the next state SHALL be SERV_D; otherwise, if iREN, SERV_I; otherwise IDLE.
REQ-024 The starving condition SHALL be true when the dcache-grant counter equals STARVE_LIM and iREN=1.
REQ-025 The dcache-grant counter SHALL increment on each IDLE->SERV_D transition taken while iREN=1, saturating at STARVE_LIM.
REQ-026 The dcache-grant counter SHALL clear on an IDLE->SERV_I transition, or when IDLE is exited with iREN=0.
REQ-027 The RAM strobes SHALL be 0 in IDLE, so a request first sampled in IDLE reaches RAM one cycle later.
REQ-028 In SERV_D, the block SHALL drive ramaddr=daddr and ramstore=dstore.
REQ-029 In SERV_D with dWEN=1, ramWEN=1 and ramREN=0 (write wins over a simultaneous dREN).
REQ-030 In SERV_D with dWEN=0, ramREN=dREN and ramWEN=0.
REQ-031 In SERV_I, the block SHALL drive ramaddr=iaddr, ramREN=1, ramWEN=0 and ramstore=0.
REQ-032 In a serving state, ramstate=ACCESS SHALL drive the granted wait output to 0 combinationally in that cycle, and the next state SHALL be IDLE.
REQ-033 The non-granted wait output SHALL stay 1 in every cycle.
REQ-034 If the granted requester deasserts its request mid-service, the block SHALL return to IDLE next cycle with no wait pulse and no counter change.
REQ-035 ramstate=ERROR in a serving state SHALL set memerr, return to IDLE, and keep the granted wait at 1 (the requester retries).
REQ-036 A 9-bit timeout counter SHALL clear on entry to a serving state and increment each serving cycle without ACCESS.
REQ-037 When the timeout counter reaches TIMEOUT, the block SHALL set memerr and return to IDLE.
REQ-038 memerr SHALL be cleared only by reset.
REQ-039 iload and dload SHALL equal ramload at all times; they are valid only in the completion cycle.

Reset
REQ-040 While nRST=0 (asynchronous), the block SHALL force: state IDLE, both counters 0, memerr=0.
REQ-041 While nRST=0, outputs SHALL be: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1.
REQ-042 Reset asserted mid-service SHALL abort the access with no wait pulse, and the block SHALL restart in IDLE.

Verification
REQ-043 Scenario: iREN=1, iaddr=0x40, ramstate=ACCESS after 2 BUSY cycles -> ramREN high from cycle 1; iwait=0 only in cycle 3 with iload=ramload.
REQ-044 Scenario: iREN=1 and dWEN=1 simultaneously, daddr=0x80, dstore=0xDEADBEEF -> SERV_D first with ramWEN=1 and ramstore=0xDEADBEEF; SERV_I after the dwait pulse.
REQ-045 Scenario: dREN held high with iREN high, STARVE_LIM=4 -> exactly 4 dcache grants, then 1 icache grant, then dcache grants resume.
REQ-046 Scenario: ramstate=ERROR during SERV_D -> memerr=1 from the next cycle; dwait stays 1; state returns to IDLE; memerr persists until nRST.
REQ-047 Scenario: ramstate stuck BUSY with TIMEOUT=255 -> return to IDLE and memerr=1 after 255 serving cycles.
REQ-048 Scenario: nRST pulsed low in cycle 2 of SERV_I -> outputs take reset values immediately; no iwait pulse.
